// File: rtl/fifo_param.sv
// fifo_param: synchronous FIFO with power-of-two depth, live almost-full/almost-empty
// thresholds and sticky overflow/underflow flags.
// Optional macro FIFO_FWFT_EN selects a first-word-fall-through read port; when it is
// undefined the read port is registered with one cycle of latency.
module fifo_param #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic                  read,
  input  logic [DATA_WIDTH-1:0] buff_in,
  input  logic [ADDR_WIDTH:0]   umb_almost_full,
  input  logic [ADDR_WIDTH:0]   umb_almost_empty,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] buffer_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  error
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DepthCount = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rd_acc, wr_acc;

  // Status flags decode straight from the registered count; thresholds are used live.
  always_comb begin
    fifo_full    = (count_q == DepthCount);
    fifo_empty   = (count_q == '0);
    almost_full  = (count_q >= umb_almost_full);
    almost_empty = (count_q <= umb_almost_empty);
    data_count   = count_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
    error        = overflow_q | underflow_q;
  end

  // Acceptance: a read frees a slot, so a full FIFO can still take a simultaneous write.
  always_comb begin
    rd_acc = read && !fifo_empty;
    wr_acc = write && (!fifo_full || rd_acc);
  end

  // Next-state for pointers, count and sticky errors; a new event beats clear_err.
  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    overflow_d  = (write && !wr_acc) || (overflow_q && !clear_err);
    underflow_d = (read && !rd_acc) || (underflow_q && !clear_err);
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= buff_in;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented combinationally; read acknowledges and pops it.
  always_comb begin
    buffer_out = mem_q[rd_ptr_q];
    valid_out  = !fifo_empty;
  end
`else
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;

  // Registered read port: load on an accepted read, hold otherwise.
  always_comb begin
    dout_d  = rd_acc ? mem_q[rd_ptr_q] : dout_q;
    valid_d = rd_acc;
  end

  // Read data register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  // Drive the read port from the register.
  always_comb begin
    buffer_out = dout_q;
    valid_out  = valid_q;
  end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed scoreboard bench for fifo_param (either read-port build).
module tb_fifo_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       write, read, clear_err;
  logic [5:0] buff_in;
  logic [3:0] uaf, uae;
  logic [5:0] buffer_out;
  logic       valid_out;
  logic [3:0] data_count;
  logic       fifo_full, fifo_empty, almost_full, almost_empty;
  logic       overflow, underflow, error;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q [$];

  fifo_param #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .write           (write),
    .read            (read),
    .buff_in         (buff_in),
    .umb_almost_full (uaf),
    .umb_almost_empty(uae),
    .clear_err       (clear_err),
    .buffer_out      (buffer_out),
    .valid_out       (valid_out),
    .data_count      (data_count),
    .fifo_full       (fifo_full),
    .fifo_empty      (fifo_empty),
    .almost_full     (almost_full),
    .almost_empty    (almost_empty),
    .overflow        (overflow),
    .underflow       (underflow),
    .error           (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge and are held for one cycle.
  task automatic step(input logic w, input logic r, input logic [5:0] d);
    write   = w;
    read    = r;
    buff_in = d;
    @(posedge clk);
    #1;
    write     = 1'b0;
    read      = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'h00);
  endtask

  // Monitor: every word the DUT presents as popped is compared with the queue head.
  always @(negedge clk) begin
    if (!reset) begin
`ifdef FIFO_FWFT_EN
      if (read && valid_out) begin
`else
      if (valid_out) begin
`endif
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected actual=%0h required=none", buffer_out);
        end else begin
          chk("pop_data", 32'(buffer_out), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; write = 1'b0; read = 1'b0; clear_err = 1'b0; buff_in = '0;
    uaf = 4'd6; uae = 4'd1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(data_count), 0);
    chk("rst_empty", 32'(fifo_empty), 1);
    chk("rst_full", 32'(fifo_full), 0);
    chk("rst_aempty", 32'(almost_empty), 1);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_error", 32'(error), 0);
    reset = 1'b0;

    // Fill with 0x01..0x08, then drain.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 6'(i));
      exp_q.push_back(6'(i));
      if (i == 7) chk("full_at7", 32'(fifo_full), 0);
    end
    chk("full_at8", 32'(fifo_full), 1);
    chk("count_8", 32'(data_count), 8);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 6'h00);
    idle(2);
    chk("empty_after_drain", 32'(fifo_empty), 1);

    // Across the pointer wrap.
    step(1'b1, 1'b0, 6'h2A); exp_q.push_back(6'h2A);
`ifdef FIFO_FWFT_EN
    chk("fwft_head", 32'(buffer_out), 32'h2A);
    chk("fwft_valid", 32'(valid_out), 1);
`else
    chk("reg_no_valid_on_write", 32'(valid_out), 0);
`endif
    step(1'b1, 1'b0, 6'h15); exp_q.push_back(6'h15);
    step(1'b0, 1'b1, 6'h00);
    step(1'b0, 1'b1, 6'h00);
    idle(2);

    // Overflow: fill with 0x21..0x28, then a write with no read is dropped.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 6'(32 + i));
      exp_q.push_back(6'(32 + i));
    end
    step(1'b1, 1'b0, 6'h3F);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_error", 32'(error), 1);
    chk("ovf_count", 32'(data_count), 8);
    idle(1);
    chk("ovf_sticky", 32'(overflow), 1);
    clear_err = 1'b1;
    idle(1);
    chk("ovf_cleared", 32'(overflow), 0);
    chk("err_cleared", 32'(error), 0);

    // Full read+write: count holds, 0x11 comes out last.
    step(1'b1, 1'b1, 6'h11); exp_q.push_back(6'h11);
    chk("full_rw_count", 32'(data_count), 8);
    chk("full_rw_no_ovf", 32'(overflow), 0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 6'h00);
    idle(2);
    chk("empty_after_rw", 32'(fifo_empty), 1);

    // Empty read+write: write taken, read rejected.
    step(1'b1, 1'b1, 6'h05); exp_q.push_back(6'h05);
    chk("erw_underflow", 32'(underflow), 1);
    chk("erw_count", 32'(data_count), 1);
`ifdef FIFO_FWFT_EN
    chk("erw_valid", 32'(valid_out), 1);
`else
    chk("erw_valid", 32'(valid_out), 0);
`endif
    step(1'b0, 1'b1, 6'h00);
    idle(2);
    // A fresh underflow in the clear cycle keeps the flag set.
    clear_err = 1'b1;
    step(1'b0, 1'b1, 6'h00);
    chk("unf_beats_clear", 32'(underflow), 1);
    clear_err = 1'b1;
    idle(1);
    chk("unf_cleared", 32'(underflow), 0);

    // Thresholds: almost_empty while count<=2, almost_full once count>=6.
    uaf = 4'd6; uae = 4'd2;
    #1;
    chk("thr_aempty_0", 32'(almost_empty), 1);
    chk("thr_afull_0", 32'(almost_full), 0);
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b0, 6'(16 + i));
      exp_q.push_back(6'(16 + i));
      chk($sformatf("thr_aempty_%0d", i), 32'(almost_empty), (i <= 2) ? 1 : 0);
      chk($sformatf("thr_afull_%0d", i), 32'(almost_full), (i >= 6) ? 1 : 0);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 6'h00);
    idle(2);

    // Asynchronous reset mid-operation empties the FIFO before any edge.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 6'h0C);
    chk("pre_rst_count", 32'(data_count), 3);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_count", 32'(data_count), 0);
    chk("async_rst_empty", 32'(fifo_empty), 1);
    chk("async_rst_valid", 32'(valid_out), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 6'h33); exp_q.push_back(6'h33);
    step(1'b0, 1'b1, 6'h00);
    idle(2);

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
